// File: rtl/float_normalize.sv
// Normalizes a raw add/multiply mantissa+exponent into hidden-bit form with round/sticky bits and zero/underflow/overflow flags.
// Latency: k+1 cycles for k left shifts (1 cycle for all others); 1 cycle always when FLOAT_NORM_LZC_EN is defined.
// Backpressure: one operand in flight; inReady only in IDLE, result held in DONE until outValid&&outReady.
module float_normalize #(
    parameter int n   = 24,
    parameter int exp = 8
) (
    input  logic           Clock,
    input  logic           Reset_n,
    input  logic [n+2:0]   rawMant,
    input  logic [exp-1:0] rawExp,
    input  logic           inValid,
    output logic           inReady,
    output logic [n-1:0]   normMant,
    output logic [exp-1:0] normExp,
    output logic           R,
    output logic           S,
    output logic           outValid,
    input  logic           outReady,
    output logic           zero,
    output logic           underflow,
    output logic           overflow
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [exp-1:0] E_ONE    = exp'(1);
    localparam logic [exp-1:0] E_MAX_M1 = {{(exp-1){1'b1}}, 1'b0};

    state_t         state_q, state_d;
    logic [n+2:0]   w_q, w_d;
    logic [exp-1:0] e_q, e_d;
    logic           zero_q, zero_d;
    logic           unf_q, unf_d;
    logic           ovf_q, ovf_d;

`ifdef FLOAT_NORM_LZC_EN
    int lz;
    int max_sh;
    int sh;
`endif

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        e_d     = e_q;
        zero_d  = zero_q;
        unf_d   = unf_q;
        ovf_d   = ovf_q;
`ifdef FLOAT_NORM_LZC_EN
        lz      = 0;
        max_sh  = 0;
        sh      = 0;
`endif
        case (state_q)
            IDLE: begin
                if (inValid) begin
                    w_d     = rawMant;
                    e_d     = rawExp;
                    zero_d  = 1'b0;
                    unf_d   = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                state_d = DONE;
                if (&e_q) begin
                    // Inf/NaN: pass through untouched
                end else if (w_q == '0) begin
                    e_d    = '0;
                    zero_d = 1'b1;
                end else if (w_q[n+2] && (e_q == E_MAX_M1)) begin
                    e_d   = '1;
                    w_d   = '0;
                    ovf_d = 1'b1;
                end else if (w_q[n+2]) begin
                    w_d = {1'b0, w_q[n+2:2], w_q[1] | w_q[0]};
                    e_d = e_q + E_ONE;
                end else if (w_q[n+1]) begin
                    // already normalized
                end else if (e_q <= E_ONE) begin
                    unf_d = 1'b1;
                end else begin
`ifdef FLOAT_NORM_LZC_EN
                    // Highest set bit wins; shift is clamped so the exponent stops at 1.
                    for (int i = 0; i <= n + 1; i++) begin
                        if (w_q[i]) lz = n + 1 - i;
                    end
                    max_sh = int'(e_q) - 1;
                    sh     = lz;
                    if (lz > max_sh) begin
                        sh    = max_sh;
                        unf_d = 1'b1;
                    end
                    w_d = w_q << sh;
                    e_d = e_q - exp'(sh);
`else
                    w_d     = {w_q[n+1:0], 1'b0};
                    e_d     = e_q - E_ONE;
                    state_d = SHIFT;
`endif
                end
            end
            DONE: begin
                if (outReady) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            w_q     <= '0;
            e_q     <= '0;
            zero_q  <= 1'b0;
            unf_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            e_q     <= e_d;
            zero_q  <= zero_d;
            unf_q   <= unf_d;
            ovf_q   <= ovf_d;
        end
    end

    assign inReady   = (state_q == IDLE);
    assign outValid  = (state_q == DONE);
    assign normMant  = w_q[n+1:2];
    assign R         = w_q[1];
    assign S         = w_q[0];
    assign normExp   = e_q;
    assign zero      = zero_q;
    assign underflow = unf_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_float_normalize.sv
// Directed-vector bench for float_normalize (n=24, exp=8); honours FLOAT_NORM_LZC_EN for expected latencies.
module tb_float_normalize;

    logic        Clock = 1'b0;
    logic        Reset_n;
    logic [26:0] rawMant;
    logic [7:0]  rawExp;
    logic        inValid;
    logic        inReady;
    logic [23:0] normMant;
    logic [7:0]  normExp;
    logic        R, S;
    logic        outValid;
    logic        outReady;
    logic        zero, underflow, overflow;

    int n_cmp = 0;
    int n_err = 0;

    float_normalize #(.n(24), .exp(8)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .rawMant(rawMant), .rawExp(rawExp),
        .inValid(inValid), .inReady(inReady), .normMant(normMant), .normExp(normExp),
        .R(R), .S(S), .outValid(outValid), .outReady(outReady),
        .zero(zero), .underflow(underflow), .overflow(overflow)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [26:0] mant;
        logic [7:0]  e;
        int          lat_it;
        int          lat_lzc;
        logic [23:0] nm;
        logic [7:0]  ne;
        logic        r, s, z, u, o;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    task automatic start_op(input logic [26:0] m, input logic [7:0] e);
        @(negedge Clock);
        check("inReady_before_accept", 64'(inReady), 64'(1'b1));
        rawMant = m;
        rawExp  = e;
        inValid = 1'b1;
        @(posedge Clock);
        #1;
        inValid = 1'b0;
    endtask

    task automatic wait_done(output int cnt);
        cnt = 0;
        do begin
            @(posedge Clock);
            #1;
            cnt++;
        end while (!outValid && cnt <= 100);
    endtask

    task automatic release_out();
        @(negedge Clock);
        outReady = 1'b1;
        @(posedge Clock);
        #1;
        outReady = 1'b0;
        check("idle_after_handshake", {62'd0, outValid, inReady}, 64'b01);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int cnt;
        int lat;
`ifdef FLOAT_NORM_LZC_EN
        lat = v.lat_lzc;
`else
        lat = v.lat_it;
`endif
        start_op(v.mant, v.e);
        wait_done(cnt);
        check($sformatf("latency[%0d]", idx), 64'(cnt), 64'(lat));
        check($sformatf("normMant[%0d]", idx), 64'(normMant), 64'(v.nm));
        check($sformatf("normExp[%0d]", idx), 64'(normExp), 64'(v.ne));
        check($sformatf("RS[%0d]", idx), {62'd0, R, S}, {62'd0, v.r, v.s});
        check($sformatf("flags_zuo[%0d]", idx), {61'd0, zero, underflow, overflow},
              {61'd0, v.z, v.u, v.o});
        release_out();
    endtask

    initial begin
        int cnt;
        int hi_cnt;

        vecs[0]  = '{27'h2000000, 8'h80, 1,  1, 24'h800000, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{27'h4000001, 8'h80, 1,  1, 24'h800000, 8'h81, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{27'h0400000, 8'h80, 4,  1, 24'h800000, 8'h7D, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{27'h0000004, 8'h03, 3,  1, 24'h000004, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{27'h0000000, 8'h55, 1,  1, 24'h000000, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{27'h4000000, 8'hFE, 1,  1, 24'h000000, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{27'h0000123, 8'hFF, 1,  1, 24'h000048, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{27'h6000003, 8'h10, 1,  1, 24'hC00000, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{27'h1000003, 8'h20, 2,  1, 24'h800001, 8'h1F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{27'h0000800, 8'h01, 1,  1, 24'h000200, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{27'h0000001, 8'h80, 26, 1, 24'h800000, 8'h67, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{27'h4000000, 8'hFD, 1,  1, 24'h800000, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        Reset_n  = 1'b0;
        rawMant  = '0;
        rawExp   = '0;
        inValid  = 1'b0;
        outReady = 1'b0;
        #12;
        check("reset_outputs", {outValid, normMant, normExp, R, S, zero, underflow, overflow},
              64'd0);
        @(negedge Clock);
        Reset_n = 1'b1;
        #1;
        check("reset_inReady", 64'(inReady), 64'(1'b1));

        for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

        // Overflow result held under backpressure; new operands ignored meanwhile
        start_op(27'h4000000, 8'hFE);
        wait_done(cnt);
        check("stall_latency", 64'(cnt), 64'd1);
        for (int c = 0; c < 5; c++) begin
            @(negedge Clock);
            inValid = 1'b1;
            rawMant = 27'h2000000;
            rawExp  = 8'h10;
            @(posedge Clock);
            #1;
            check($sformatf("stall_hold[%0d]", c),
                  {outValid, inReady, normMant, normExp, R, S, zero, underflow, overflow},
                  {1'b1, 1'b0, 24'h000000, 8'hFF, 2'b00, 3'b001});
        end
        inValid = 1'b0;
        release_out();
        hi_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge Clock);
            #1;
            if (outValid) hi_cnt++;
        end
        check("no_queued_operand", 64'(hi_cnt), 64'd0);

        // Asynchronous reset while an operand is mid-normalization
        start_op(27'h0000100, 8'h80);
        #2;
        Reset_n = 1'b0;
        #1;
        check("midshift_reset_outputs", {outValid, normMant, normExp, zero, underflow, overflow},
              64'd0);
        check("midshift_reset_inReady", 64'(inReady), 64'(1'b1));
        @(negedge Clock);
        Reset_n = 1'b1;
        hi_cnt = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge Clock);
            #1;
            if (outValid) hi_cnt++;
        end
        check("discarded_operand_no_outValid", 64'(hi_cnt), 64'd0);
        run_vec(100, vecs[1]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/float_normalize.md
FLOAT_NORMALIZE -- requirements
Module: float_normalize

Interface
REQ-001 Parameter n, default 24, mantissa width including hidden bit, equal to the rounding stage's n.
REQ-002 Parameter exp, default 8, exponent width.
REQ-003 Clock  input  1  sole clock; all state updates on posedge.
REQ-004 Reset_n  input  1  reset, asynchronous, active-low.
REQ-005 rawMant  input  n+3  {carry[n+2], mantissa[n+1:2], guard[1], sticky[0]} from the add/multiply stage.
REQ-006 rawExp  input  exp  unnormalized exponent.
REQ-007 inValid  input  1  rawMant/rawExp valid.
REQ-008 inReady  output  1  block can accept an operand.
REQ-009 normMant  output  n  normalized mantissa, hidden bit at [n-1].
REQ-010 normExp  output  exp  adjusted exponent.
REQ-011 R  output  1  round bit; S  output  1  sticky bit.
REQ-012 outValid  output  1  result valid; outReady  input  1  downstream accepts.
REQ-013 zero, underflow, overflow  output  1 each  result flags, valid with outValid.

Function
REQ-014 FSM states IDLE, SHIFT, DONE; inReady=1 only in IDLE; accept when inValid&&inReady at a posedge.
REQ-015 Accept: load rawMant into working vector W (n+3 bits), rawExp into E; go to SHIFT.
REQ-016 SHIFT evaluates, in priority order, once per cycle:
- E all-ones: go DONE unchanged (Inf/NaN passthrough).
- W==0: E<=0, zero=1, go DONE.
- W[n+2]=1 and E==all-ones-1: E<=all-ones, W<=0, overflow=1, go DONE.
- W[n+2]=1: W<=W>>1 with W[0]<=old W[1]|old W[0]; E<=E+1; go DONE.
- W[n+1]=1: go DONE, no change.
- E<=1: underflow=1, go DONE, no change.
- else: W<=W<<1, LSB 0; E<=E-1; stay SHIFT.
REQ-017 Outputs driven from registers: normMant=W[n+1:2], R=W[1], S=W[0], normExp=E.
REQ-018 DONE: outValid=1; stays DONE, outputs stable, until outValid&&outReady at a posedge, then IDLE.
REQ-019 Latency: k left shifts needed → outValid visible after posedge k+1 counted from accept edge (edge 0); k=0, right-shift, zero, overflow cases → after edge 1.
REQ-020 Left shifts capped at n+1 per operand; exceeding impossible by REQ-016 ordering.
REQ-021 Flags cleared on each accept; at most one of zero/underflow/overflow set.
REQ-022 inValid while not in IDLE is ignored; no operand queued.
REQ-023 outReady with outValid low has no effect.

Reset
REQ-024 Reset_n low asynchronously forces IDLE, W=0, E=0, outValid=0, all flags 0; outputs therefore 0; inReady=1 after release.
REQ-025 Reset mid-SHIFT or mid-DONE discards operand; no outValid produced for it.

Configuration
REQ-026 Macro FLOAT_NORM_LZC_EN: defined → SHIFT performs full left normalization in one cycle via leading-zero count, clamped so E does not go below 1 (underflow set if clamped); every operand latency = 1 edge.
REQ-027 Undefined → iterative one-bit-per-cycle shifting per REQ-016; all other behaviour identical.

Verification
REQ-028 rawMant=27'h2000000, rawExp=8'h80 → after edge 1: normMant=24'h800000, normExp=8'h80, R=0, S=0, flags 0.
REQ-029 rawMant=27'h4000001, rawExp=8'h80 → after edge 1: normMant=24'h800000, normExp=8'h81, R=0, S=1.
REQ-030 rawMant=27'h0400000, rawExp=8'h80 → after edge 4 (edge 1 with LZC): normMant=24'h800000, normExp=8'h7D.
REQ-031 rawMant=27'h0000004, rawExp=8'h03 → after edge 3: normExp=8'h01, normMant=24'h000004, underflow=1; rawMant=0 → zero=1, normExp=0 after edge 1.
REQ-032 rawMant=27'h4000000, rawExp=8'hFE → overflow=1, normExp=8'hFF, normMant=0; hold outReady=0 5 cycles → outputs stable, inReady=0.
REQ-033 Reset_n low during SHIFT of 27'h0000100 → immediate IDLE, outValid stays 0, next operand processed normally.
